// File: rtl/logic_gate_pkg.sv
// Shared constants, FSM state type and golden gate function
// for the logic_gates self-test sequencer.
package logic_gate_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  localparam int NUM_GATES   = 7;
  localparam int NUM_VECTORS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [NUM_GATES-1:0] gate_expected(
    input logic a,
    input logic b
  );
    logic [NUM_GATES-1:0] e;
    e            = '0;
    e[GATE_AND]  = a & b;
    e[GATE_OR]   = a | b;
    e[GATE_NOT]  = ~a;
    e[GATE_NAND] = ~(a & b);
    e[GATE_NOR]  = ~(a | b);
    e[GATE_XOR]  = a ^ b;
    e[GATE_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/logic_gate_bist_golden.sv
// Combinational expected-value model of the seven gates
// for the vector currently driven on a/b.
module logic_gate_golden
  import logic_gate_pkg::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_GATES-1:0] expected_o
);

  assign expected_o = gate_expected(a_i, b_i);

endmodule

// File: rtl/logic_gate_bist.sv
// Start/done-controlled self-test: walks {a,b} through all four
// vectors, samples the gate outputs and accumulates pass/fail.
module logic_gate_bist
  import logic_gate_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  input  logic [NUM_GATES-1:0] gates_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [3:0]           fail_vec,
  output logic [2:0]           fail_count,
  output logic [NUM_GATES-1:0] err_mask
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           vec_q, vec_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pass_q, pass_d;
  logic [3:0]           fvec_q, fvec_d;
  logic [2:0]           fcnt_q, fcnt_d;
  logic [NUM_GATES-1:0] emask_q, emask_d;
  logic [NUM_GATES-1:0] expected;
  logic [NUM_GATES-1:0] mismatch;

  logic_gate_golden u_golden (
    .a_i        (vec_q[1]),
    .b_i        (vec_q[0]),
    .expected_o (expected)
  );

  assign mismatch = gates_in ^ expected;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fvec_d  = fvec_q;
    fcnt_d  = fcnt_q;
    emask_d = emask_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = 2'd0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          fvec_d  = '0;
          fcnt_d  = '0;
          emask_d = '0;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          emask_d = emask_q | mismatch;
          if (|mismatch) begin
            fvec_d[vec_q] = 1'b1;
            fcnt_d        = fcnt_q + 3'd1;
          end
          if (vec_q == 2'd3) begin
            state_d = DONE;
            vec_d   = 2'd0;
            pass_d  = (fcnt_d == 3'd0);
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fvec_q  <= '0;
      fcnt_q  <= '0;
      emask_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fvec_q  <= fvec_d;
      fcnt_q  <= fcnt_d;
      emask_q <= emask_d;
    end
  end

  // a/b come straight from the vector register
  assign a          = vec_q[1];
  assign b          = vec_q[0];
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign fail_vec   = fvec_q;
  assign fail_count = fcnt_q;
  assign err_mask   = emask_q;

endmodule

// File: tb/tb_logic_gate_bist.sv
// Directed bench: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances,
// each fed by a gate model with selectable faults.
module tb_logic_gate_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start1;
  logic       a4, b4, a1, b1;
  logic [6:0] g4, g1;
  logic       busy4, done4, pass4;
  logic       busy1, done1, pass1;
  logic [3:0] fv4, fv1;
  logic [2:0] fc4, fc1;
  logic [6:0] em4, em1;
  int         mode4;
  int         ntests = 0;
  int         nfail  = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] gm(input logic a, input logic b, input int mode);
    logic [6:0] g;
    g[0] = a & b;
    g[1] = a | b;
    g[2] = (mode == 2) ? ~b : ~a;
    g[3] = ~(a & b);
    g[4] = ~(a | b);
    g[5] = (mode == 1) ? 1'b0 : (a ^ b);
    g[6] = ~(a ^ b);
    return g;
  endfunction

  always_comb g4 = gm(a4, b4, mode4);
  always_comb g1 = gm(a1, b1, 0);

  logic_gate_bist #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .a(a4), .b(b4), .gates_in(g4),
    .busy(busy4), .done(done4), .pass(pass4),
    .fail_vec(fv4), .fail_count(fc4), .err_mask(em4)
  );

  logic_gate_bist #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .gates_in(g1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_vec(fv1), .fail_count(fc1), .err_mask(em1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run4(input int mode, input logic ep, input logic [3:0] efv,
                      input logic [2:0] efc, input logic [6:0] eem,
                      input bit repulse);
    mode4 = mode;
    @(negedge clk);
    start4 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start4 = repulse && (k == 5);
      chk("run_bdab", {busy4, done4, a4, b4}, {2'b10, 2'((k - 1) / 4)});
    end
    @(negedge clk);
    chk("done_bdab", {busy4, done4, a4, b4}, 4'b0100);
    chk("done_pass", pass4, ep);
    chk("done_fvec", fv4, efv);
    chk("done_fcnt", fc4, efc);
    chk("done_emask", em4, eem);
    start4 = repulse;
    @(negedge clk);
    start4 = 1'b0;
    chk("post_bdab", {busy4, done4, a4, b4}, 4'b0000);
    chk("post_res", {pass4, fv4, fc4, em4}, {ep, efv, efc, eem});
    @(negedge clk);
    chk("idle_bd", {busy4, done4}, 2'b00);
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; mode4 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst4", {a4, b4, busy4, done4, pass4, fv4, fc4, em4}, 0);
    chk("rst1", {a1, b1, busy1, done1, pass1, fv1, fc1, em1}, 0);
    rst = 1'b0;

    run4(0, 1'b1, 4'b0000, 3'd0, 7'b0000000, 1'b0);
    run4(1, 1'b0, 4'b0110, 3'd2, 7'b0100000, 1'b0);
    run4(2, 1'b0, 4'b0110, 3'd2, 7'b0000100, 1'b0);
    run4(0, 1'b1, 4'b0000, 3'd0, 7'b0000000, 1'b1);

    // abort while vector 2 is applied, after vector 1 has failed
    mode4 = 1;
    @(negedge clk);
    start4 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start4 = 1'b0;
    end
    chk("pre_rst_ab", {busy4, a4, b4}, 3'b110);
    chk("pre_rst_fv", {fv4, fc4}, {4'b0010, 3'd1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst", {a4, b4, busy4, done4, pass4, fv4, fc4, em4}, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("no_done", {busy4, done4}, 2'b00);
    end
    run4(0, 1'b1, 4'b0000, 3'd0, 7'b0000000, 1'b0);

    // HOLD_CYCLES=1, back-to-back passes
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      start1 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        start1 = 1'b0;
        chk("h1_bdab", {busy1, done1, a1, b1}, {2'b10, 2'(k - 1)});
      end
      @(negedge clk);
      chk("h1_done", {busy1, done1, a1, b1}, 4'b0100);
      chk("h1_res", {pass1, fv1, fc1, em1}, {1'b1, 14'd0});
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
